// File: rtl/eth_tx_arbiter_pkg.sv
// Shared Ethernet types: addressing bundle and TX arbiter state.
// Imported by the arbiter, its sub-module and benches.
package eth_tx_arbiter_pkg;

  localparam int ETH_ARB_MAX_REQ = 8;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } IPInfo;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_LAUNCH,
    ARB_WAIT_START,
    ARB_WAIT_DONE,
    ARB_GAP
  } eth_arb_state_t;

  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_round_robin.sv
// Combinational round-robin pick: search starts one past last.
// The pointer register lives in the parent.
module round_robin_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = arb_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          grant_valid,
  output logic [IW-1:0] grant
);

  logic [N-1:0] sh;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    sh          = '0;
    for (int i = N; i >= 1; i--) begin
      sh = req >> ((int'(last) + i) % N);
      if (sh[0]) begin
        grant_valid = 1'b1;
        grant       = IW'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares one UDP transmitter among NUM_REQ requesters:
// round-robin grant, send pulse, ready tracking, gap, timeout.
module eth_tx_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_BITS      = 64,
  parameter int GAP_CYCLES     = 96,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0][DATA_BITS-1:0]  req_data,
  input  IPInfo [NUM_REQ-1:0]                req_ip_info,
  output logic [NUM_REQ-1:0]                 ack,
  output logic [NUM_REQ-1:0]                 done,
  output logic                               timeout,
  output logic                               busy,
  output logic [DATA_BITS-1:0]               tx_data,
  output IPInfo                              tx_ip_info,
  output logic                               tx_send,
  input  logic                               tx_ready
);

  localparam int IW   = arb_idx_w(NUM_REQ);
  localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES)
                      ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] G_LOAD = TW'(GAP_CYCLES - 1);

  eth_arb_state_t state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [IW-1:0]  last_q, last_d;
  logic [IW-1:0]  gsel_q, gsel_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic           tout_q, tout_d;
  logic           send_q, send_d;
  logic           busy_q, busy_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  IPInfo          ip_q, ip_d;

  logic           grant_valid;
  logic [IW-1:0]  grant;
  logic           expired;

  round_robin_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req         (req),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign expired = (timer_q == '0);

  // Next-state, timer and output pulse decode.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    last_d  = last_q;
    gsel_d  = gsel_q;
    data_d  = data_q;
    ip_d    = ip_q;
    ack_d   = '0;
    done_d  = '0;
    tout_d  = 1'b0;
    send_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid && tx_ready) begin
          gsel_d  = grant;
          data_d  = req_data[grant];
          ip_d    = req_ip_info[grant];
          ack_d   = NUM_REQ'(1) << grant;
          state_d = ARB_LAUNCH;
        end
      end
      ARB_LAUNCH: begin
        send_d  = 1'b1;
        timer_d = T_LOAD;
        state_d = ARB_WAIT_START;
      end
      ARB_WAIT_START: begin
        if (!tx_ready) begin
          timer_d = T_LOAD;
          state_d = ARB_WAIT_DONE;
        end else if (expired) begin
          done_d  = NUM_REQ'(1) << gsel_q;
          tout_d  = 1'b1;
          timer_d = G_LOAD;
          state_d = ARB_GAP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ARB_WAIT_DONE: begin
        if (tx_ready || expired) begin
          done_d  = NUM_REQ'(1) << gsel_q;
          tout_d  = !tx_ready;
          timer_d = G_LOAD;
          state_d = ARB_GAP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ARB_GAP: begin
        if (expired) begin
          last_d  = gsel_q;
          state_d = ARB_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      timer_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      gsel_q  <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      tout_q  <= 1'b0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      ip_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      gsel_q  <= gsel_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      ip_q    <= ip_d;
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign timeout    = tout_q;
  assign busy       = busy_q;
  assign tx_data    = data_q;
  assign tx_ip_info = ip_q;
  assign tx_send    = send_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed + randomized bench for eth_tx_arbiter.
// Expected grants and timing come from a small rule-level model.
module tb_eth_tx_arbiter;
  import eth_tx_arbiter_pkg::*;

  localparam int N   = 2;
  localparam int DB  = 64;
  localparam int GAP = 8;
  localparam int TO  = 100;

  logic clk = 1'b0;
  logic resetn;
  logic [N-1:0] req;
  logic [N-1:0][DB-1:0] req_data;
  IPInfo [N-1:0] req_ip_info;
  logic [N-1:0] ack, done;
  logic timeout, busy;
  logic [DB-1:0] tx_data;
  IPInfo tx_ip_info;
  logic tx_send, tx_ready;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  int last_m;
  logic [DB-1:0] exp_data;
  IPInfo exp_ip;
  int last_done;

  eth_tx_arbiter #(
    .NUM_REQ        (N),
    .DATA_BITS      (DB),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .req_data    (req_data),
    .req_ip_info (req_ip_info),
    .ack         (ack),
    .done        (done),
    .timeout     (timeout),
    .busy        (busy),
    .tx_data     (tx_data),
    .tx_ip_info  (tx_ip_info),
    .tx_send     (tx_send),
    .tx_ready    (tx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic IPInfo rand_ip();
    IPInfo ip;
    logic [63:0] t;
    t = {$urandom, $urandom};
    ip.dst_mac  = t[47:0];
    ip.src_ip   = $urandom;
    ip.dst_ip   = $urandom;
    ip.src_port = 16'($urandom);
    ip.dst_port = 16'($urandom);
    return ip;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++)
      if (r[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic quiet(input int n, input string tag);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      step();
      if (done !== '0 || tx_send !== 1'b0) bad = 1'b1;
    end
    chk(tag, 256'(bad), 256'(0));
  endtask

  task automatic grant_expect(input string tag, output int e);
    int n;
    e = rr_pick(req, last_m);
    exp_data = (e >= 0) ? req_data[e] : '0;
    exp_ip   = (e >= 0) ? req_ip_info[e] : '0;
    n = 0;
    while (ack === '0 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_ack"}, 256'(ack), 256'(oh(e)));
    chk({tag, "_data"}, 256'(tx_data), 256'(exp_data));
    chk({tag, "_ip"}, 256'(tx_ip_info), 256'(exp_ip));
    if (e >= 0) last_m = e;
  endtask

  task automatic run_frame(input string tag, input int e,
                           input int drop, input int len);
    step();
    chk({tag, "_send"}, 256'(tx_send), 256'(1));
    quiet(drop, {tag, "_predrop"});
    tx_ready = 1'b0;
    quiet(len, {tag, "_inframe"});
    tx_ready = 1'b1;
    step();
    chk({tag, "_done"}, 256'(done), 256'(oh(e)));
    chk({tag, "_tout"}, 256'(timeout), 256'(0));
    chk({tag, "_hold"}, 256'(tx_data), 256'(exp_data));
    last_done = cyc;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ack"}, 256'(ack), 256'(0));
    chk({tag, "_done"}, 256'(done), 256'(0));
    chk({tag, "_tout"}, 256'(timeout), 256'(0));
    chk({tag, "_send"}, 256'(tx_send), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_data"}, 256'(tx_data), 256'(0));
    chk({tag, "_ip"}, 256'(tx_ip_info), 256'(0));
  endtask

  initial begin
    int g, c0, n;
    logic bad;
    req = '0;
    req_data = '0;
    req_ip_info = '0;
    tx_ready = 1'b1;
    resetn = 1'b0;
    last_m = N - 1;
    last_done = 0;
    step();
    step();
    chk_reset("rst");
    resetn = 1'b1;
    step();

    // Single requester, nominal frame.
    for (int i = 0; i < N; i++) begin
      req_data[i] = {$urandom, $urandom};
      req_ip_info[i] = rand_ip();
    end
    req = 2'b01;
    c0 = cyc;
    grant_expect("t1", g);
    chk("t1_lat", 256'(cyc - c0), 256'(1));
    req = '0;
    run_frame("t1", g, 3, 50);

    // Contention with payload changes after each ack.
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      grant_expect("t2", g);
      chk("t2_gap", 256'(cyc - last_done), 256'(GAP + 1));
      if (k == 3) req = '0;
      else begin
        req_data[g] = {$urandom, $urandom};
        req_ip_info[g] = rand_ip();
      end
      run_frame("t2", g, $urandom_range(1, 5), $urandom_range(5, 40));
    end

    // Gap boundary then stuck transmitter.
    quiet(GAP - 1, "t3_gap");
    chk("t3_busy_gap", 256'(busy), 256'(1));
    step();
    chk("t3_idle0", 256'(busy), 256'(0));
    req = 2'b01;
    grant_expect("t3", g);
    req = '0;
    step();
    chk("t3_send", 256'(tx_send), 256'(1));
    c0 = cyc;
    n = 0;
    while (done === '0 && n < 300) begin
      step();
      n++;
    end
    chk("t3_lat", 256'(cyc - c0), 256'(TO + 1));
    chk("t3_done", 256'(done), 256'(oh(g)));
    chk("t3_tout", 256'(timeout), 256'(1));
    quiet(GAP - 1, "t3_gap2");
    chk("t3_busy2", 256'(busy), 256'(1));
    step();
    chk("t3_idle", 256'(busy), 256'(0));

    // Hung frame; requester 1 waits behind it.
    req = 2'b01;
    grant_expect("t4", g);
    req = 2'b10;
    step();
    chk("t4_send", 256'(tx_send), 256'(1));
    quiet(2, "t4_pre");
    tx_ready = 1'b0;
    step();
    c0 = cyc;
    n = 0;
    bad = 1'b0;
    while (done === '0 && n < 300) begin
      step();
      n++;
      if (tx_send !== 1'b0) bad = 1'b1;
    end
    chk("t4_lat", 256'(cyc - c0), 256'(TO + 1));
    chk("t4_done", 256'(done), 256'(oh(g)));
    chk("t4_tout", 256'(timeout), 256'(1));
    repeat (GAP + 5) begin
      step();
      if (ack !== '0 || tx_send !== 1'b0) bad = 1'b1;
    end
    chk("t4_nogrant", 256'(bad), 256'(0));
    tx_ready = 1'b1;
    c0 = cyc;
    grant_expect("t4b", g);
    chk("t4b_lat", 256'(cyc - c0), 256'(1));
    req = '0;

    // Reset during WAIT_DONE.
    step();
    chk("t5_send", 256'(tx_send), 256'(1));
    quiet(2, "t5_pre");
    tx_ready = 1'b0;
    quiet(4, "t5_frame");
    resetn = 1'b0;
    step();
    chk_reset("t5_rst");
    resetn = 1'b1;
    tx_ready = 1'b1;
    last_m = N - 1;
    quiet(20, "t5_nodone");
    req = 2'b11;
    grant_expect("t5a", g);
    req = 2'b10;
    run_frame("t5a", g, 2, 10);
    grant_expect("t5b", g);
    req = '0;
    run_frame("t5b", g, $urandom_range(1, 5), $urandom_range(5, 40));

    // Withdrawn request while transmitter busy.
    quiet(GAP, "t6_gap");
    tx_ready = 1'b0;
    req_data[1] = {$urandom, $urandom};
    req = 2'b10;
    step();
    req = '0;
    bad = 1'b0;
    repeat (GAP) begin
      step();
      if (ack !== '0) bad = 1'b1;
    end
    tx_ready = 1'b1;
    repeat (5) begin
      step();
      if (ack !== '0) bad = 1'b1;
    end
    chk("t6_noack", 256'(bad), 256'(0));
    chk("t6_idle", 256'(busy), 256'(0));
    chk("t6_hold", 256'(tx_data), 256'(exp_data));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
